hdmi_pixel_packer: RTL and testbench
====================================

Name: hdmi_pixel_packer

Overview:
Parametrised successor to the HDMI ingester. Takes one pixel per clock from the HDMI receiver interface and packs pixels LSB-first into FIFO-width words, either densely (bit-packed) or padded (one pixel per word). Flushes the residual partial word at frame end. Counts words dropped because the downstream FIFO was full. Sits between the HDMI receiver pins/decoder and the frame-buffer write FIFO, all in the HDMI pixel clock domain.

Parameters:
PIXEL_WIDTH, 24, bits per incoming pixel; 1 <= PIXEL_WIDTH <= WORD_WIDTH.
WORD_WIDTH, 32, FIFO data word width.
PACK_MODE, 1, 1 = dense bit-packing across word boundaries; 0 = each pixel zero-extended into its own word.
OVF_WIDTH, 16, width of the saturating dropped-word counter.

Ports:
i_clock  in  1  HDMI pixel clock; all logic on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_hdmiData  in  PIXEL_WIDTH  pixel data.
i_hdmiEnable  in  1  pixel valid (data enable); pixel is sampled when high.
i_hdmiFrameEnd  in  1  one-cycle pulse, last cycle of a frame; may coincide with the final enabled pixel.
i_fifoFull  in  1  downstream FIFO full.
i_clearOverflow  in  1  synchronous clear of overflow counter and flag.
o_dataValid  out  1  o_fifoData valid this cycle (FIFO write enable).
o_fifoData  out  WORD_WIDTH  packed word.
o_overflow  out  1  sticky: at least one word dropped since reset or clear.
o_overflowCount  out  OVF_WIDTH  dropped words, saturating at all-ones.

Behaviour:
- Reset (asynchronous, active-high): o_dataValid=0, o_fifoData=0, o_overflow=0, o_overflowCount=0. Accumulator is emptied, bit count set to 0, and any pending flush is cleared. A reset mid-frame discards residual bits.
- Accumulator: PIXEL_WIDTH+WORD_WIDTH bits, plus a bit count 0..WORD_WIDTH-1 between cycles.
- Dense mode: an enabled pixel is placed at bit offset count.
  - If count+PIXEL_WIDTH >= WORD_WIDTH, the low WORD_WIDTH bits are emitted. The remainder shifts down and count becomes count+PIXEL_WIDTH-WORD_WIDTH.
  - Otherwise count increases by PIXEL_WIDTH.
- Padded mode: every enabled pixel is emitted as {zeros, pixel}. count stays 0.
- Latency: a word appears on o_fifoData/o_dataValid on the clock edge after the pixel that completes it is sampled, so output is registered with 1-cycle latency.
- o_dataValid is high for exactly one cycle per word. o_fifoData holds its value when o_dataValid=0.
- Frame-end flush: when i_hdmiFrameEnd=1, the enabled pixel in that same cycle (if any) is included first.
  - If residual count>0, the residual is zero-padded to WORD_WIDTH and emitted.
  - If that cycle already emits a full word, the flush word goes into a one-entry pending register and is emitted the following cycle.
  - Accumulator and count return to 0 on the frame-end cycle.
  - If count is 0 after the pixel, no flush word is produced.
- Pixel in the cycle after a deferred flush: the pending word is emitted and the pixel enters the empty accumulator. At most one word is emitted per cycle; the pending flush can never collide with a full word because count restarts at 0 and PIXEL_WIDTH <= WORD_WIDTH.
- Full handling: the FIFO write is suppressed, not stalled.
  - If i_fifoFull=1 on the edge where a word would be emitted, o_dataValid stays 0 and the word is lost.
  - o_overflowCount increments, saturating at all-ones, and o_overflow is set.
  - Packing alignment continues unchanged, with no re-synchronisation.
- i_clearOverflow=1 clears the counter and flag. If a drop occurs in the same cycle, the counter becomes 1 and the flag 1.
- i_hdmiEnable=0 with no frame end: state holds and no output.

Decomposition:
- Shared package hdmi_pkg: default PIXEL_WIDTH/WORD_WIDTH, PACK_MODE encodings (PACK_DENSE=1, PACK_PADDED=0), and an elaboration check that PIXEL_WIDTH <= WORD_WIDTH.
- One natural sub-module: sat_counter (OVF_WIDTH-parametrised saturating counter with increment and synchronous clear), reusable elsewhere.

Test Plan:
- Dense 24->32: pixels 0x112233, 0x445566, 0x778899, 0xAABBCC on consecutive cycles -> words 0x66112233, 0x88994455, 0xAABBCC77, each valid one cycle after its completing pixel. No flush at frame end, since count=0.
- Flush: pixels 0x112233, 0x445566, 0x778899 with i_hdmiFrameEnd on the third -> 0x66112233, 0x88994455, then 0x00000077 on the next cycle. The next frame's first word starts fresh.
- Padded mode: pixel 0xABCDEF -> 0x00ABCDEF, one word per pixel. Frame end produces no extra word.
- Overflow: i_fifoFull=1 while the second word of the dense sequence would emit -> it is dropped, o_overflowCount=1, o_overflow=1, and the third word 0xAABBCC77 is still correct. Clear pulse -> count 0, flag 0. Saturation check with OVF_WIDTH=2: five drops -> count 3.
- Async reset mid-word after one pixel (count=24) -> outputs 0 immediately, without a clock edge. After release, pixel 0x445566 followed by 0x778899 yields 0x99445566, proving no residual from before reset.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI pixel-clock-domain ingest blocks.
// Default geometry, pack-mode encodings and the width sanity rule.
package hdmi_pkg;

  localparam int DEFAULT_PIXEL_WIDTH = 24;
  localparam int DEFAULT_WORD_WIDTH  = 32;

  localparam logic PACK_PADDED = 1'b0;
  localparam logic PACK_DENSE  = 1'b1;

  // A pixel must fit in one FIFO word, otherwise packing can emit two words per cycle.
  function automatic logic widthsOk(input int pixelWidth, input int wordWidth);
    return (pixelWidth >= 1) && (pixelWidth <= wordWidth);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together
// yield a count of one so that a same-cycle event is never lost.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] countNext_s;

  // Next count: clear wins over hold, saturate at all-ones.
  always_comb begin
    countNext_s = count_r;
    if (clear && increment) begin
      countNext_s = WIDTH'(1'b1);
    end else if (clear) begin
      countNext_s = {WIDTH{1'b0}};
    end else if (increment && !(&count_r)) begin
      countNext_s = count_r + WIDTH'(1'b1);
    end else begin
      countNext_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= countNext_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hdmi_pixel_packer.sv
// Packs one HDMI pixel per clock LSB-first into FIFO words (dense or padded),
// flushes the residual at frame end and counts words lost to a full FIFO.
module hdmi_pixel_packer
  import hdmi_pkg::*;
#(
  parameter int   PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int   WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter logic PACK_MODE   = PACK_DENSE,
  parameter int   OVF_WIDTH   = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [PIXEL_WIDTH-1:0] i_hdmiData,
  input  logic                   i_hdmiEnable,
  input  logic                   i_hdmiFrameEnd,
  input  logic                   i_fifoFull,
  input  logic                   i_clearOverflow,
  output logic                   o_dataValid,
  output logic [WORD_WIDTH-1:0]  o_fifoData,
  output logic                   o_overflow,
  output logic [OVF_WIDTH-1:0]   o_overflowCount
);

  localparam int ACC_W = PIXEL_WIDTH + WORD_WIDTH;
  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int SUM_W = $clog2(ACC_W) + 1;

  if (!widthsOk(PIXEL_WIDTH, WORD_WIDTH)) begin : gBadWidth
    $error("hdmi_pixel_packer: PIXEL_WIDTH must be in 1..WORD_WIDTH");
  end

  logic [ACC_W-1:0]      accData_r;
  logic [CNT_W-1:0]      bitCount_r;
  logic                  pendingValid_r;
  logic [WORD_WIDTH-1:0] pendingWord_r;
  logic                  dataValid_r;
  logic [WORD_WIDTH-1:0] fifoData_r;
  logic                  overflow_r;

  logic [ACC_W-1:0]      placedAcc_s;
  logic [SUM_W-1:0]      bitSum_s;
  logic                  fullEmit_s;
  logic [WORD_WIDTH-1:0] fullWord_s;
  logic [ACC_W-1:0]      residAcc_s;
  logic [SUM_W-1:0]      residCount_s;
  logic                  flushNeed_s;
  logic [WORD_WIDTH-1:0] flushWord_s;
  logic                  emit_s;
  logic [WORD_WIDTH-1:0] emitWord_s;
  logic                  drop_s;
  logic [ACC_W-1:0]      nextAcc_s;
  logic [CNT_W-1:0]      nextCount_s;
  logic                  nextPending_s;
  logic [WORD_WIDTH-1:0] nextPendingWord_s;

  // Packing, flush and word-selection datapath.
  always_comb begin
    placedAcc_s  = accData_r | ({{WORD_WIDTH{1'b0}}, i_hdmiData} << bitCount_r);
    bitSum_s     = SUM_W'(bitCount_r) + SUM_W'(PIXEL_WIDTH);
    fullEmit_s   = 1'b0;
    fullWord_s   = {WORD_WIDTH{1'b0}};
    residAcc_s   = accData_r;
    residCount_s = SUM_W'(bitCount_r);

    if (i_hdmiEnable) begin
      if (PACK_MODE == PACK_PADDED) begin
        fullEmit_s = 1'b1;
        fullWord_s = WORD_WIDTH'(i_hdmiData);
      end else if (bitSum_s >= SUM_W'(WORD_WIDTH)) begin
        fullEmit_s   = 1'b1;
        fullWord_s   = placedAcc_s[WORD_WIDTH-1:0];
        residAcc_s   = placedAcc_s >> WORD_WIDTH;
        residCount_s = bitSum_s - SUM_W'(WORD_WIDTH);
      end else begin
        residAcc_s   = placedAcc_s;
        residCount_s = bitSum_s;
      end
    end else begin
      residAcc_s   = accData_r;
      residCount_s = SUM_W'(bitCount_r);
    end

    // Bits above the residual count are always zero, so the low word is already padded.
    flushNeed_s = i_hdmiFrameEnd && (residCount_s != {SUM_W{1'b0}});
    flushWord_s = residAcc_s[WORD_WIDTH-1:0];

    if (i_hdmiFrameEnd) begin
      nextAcc_s   = {ACC_W{1'b0}};
      nextCount_s = {CNT_W{1'b0}};
    end else begin
      nextAcc_s   = residAcc_s;
      nextCount_s = residCount_s[CNT_W-1:0];
    end

    // A pending flush and a full word are mutually exclusive; a flush takes the
    // output slot if free, else it is parked for the following cycle.
    emit_s            = 1'b0;
    emitWord_s        = {WORD_WIDTH{1'b0}};
    nextPending_s     = 1'b0;
    nextPendingWord_s = pendingWord_r;
    if (pendingValid_r) begin
      emit_s     = 1'b1;
      emitWord_s = pendingWord_r;
    end else if (fullEmit_s) begin
      emit_s     = 1'b1;
      emitWord_s = fullWord_s;
    end else begin
      emit_s     = 1'b0;
      emitWord_s = {WORD_WIDTH{1'b0}};
    end

    if (flushNeed_s) begin
      if (emit_s) begin
        nextPending_s     = 1'b1;
        nextPendingWord_s = flushWord_s;
      end else begin
        emit_s     = 1'b1;
        emitWord_s = flushWord_s;
      end
    end else begin
      nextPending_s = 1'b0;
    end

    drop_s = emit_s && i_fifoFull;
  end

  // Accumulator, pending flush and registered FIFO write port.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      accData_r      <= {ACC_W{1'b0}};
      bitCount_r     <= {CNT_W{1'b0}};
      pendingValid_r <= 1'b0;
      pendingWord_r  <= {WORD_WIDTH{1'b0}};
      dataValid_r    <= 1'b0;
      fifoData_r     <= {WORD_WIDTH{1'b0}};
    end else begin
      accData_r      <= nextAcc_s;
      bitCount_r     <= nextCount_s;
      pendingValid_r <= nextPending_s;
      pendingWord_r  <= nextPendingWord_s;
      dataValid_r    <= emit_s && !i_fifoFull;
      if (emit_s && !i_fifoFull) begin
        fifoData_r <= emitWord_s;
      end
    end
  end

  // Sticky overflow flag; a drop in the clear cycle still sets it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (i_clearOverflow) begin
      overflow_r <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(OVF_WIDTH)
  ) uDropCounter (
    .clock    (i_clock),
    .reset    (i_reset),
    .clear    (i_clearOverflow),
    .increment(drop_s),
    .count    (o_overflowCount)
  );

  assign o_dataValid = dataValid_r;
  assign o_fifoData  = fifoData_r;
  assign o_overflow  = overflow_r;

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Directed bench: dense, padded and 2-bit-counter packer instances share one stimulus stream.
module tb_hdmi_pixel_packer;
  import hdmi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] hdmiData = 24'h0;
  logic        hdmiEnable = 1'b0;
  logic        hdmiFrameEnd = 1'b0;
  logic        fifoFull = 1'b0;
  logic        clearOverflow = 1'b0;

  logic        dValid, pValid, sValid;
  logic [31:0] dData, pData, sData;
  logic        dOvf, pOvf, sOvf;
  logic [15:0] dOvfCount, pOvfCount;
  logic [1:0]  sOvfCount;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  hdmi_pixel_packer #(.PIXEL_WIDTH(24), .WORD_WIDTH(32), .PACK_MODE(PACK_DENSE), .OVF_WIDTH(16)) uDense (
    .i_clock(clock), .i_reset(reset), .i_hdmiData(hdmiData), .i_hdmiEnable(hdmiEnable),
    .i_hdmiFrameEnd(hdmiFrameEnd), .i_fifoFull(fifoFull), .i_clearOverflow(clearOverflow),
    .o_dataValid(dValid), .o_fifoData(dData), .o_overflow(dOvf), .o_overflowCount(dOvfCount));

  hdmi_pixel_packer #(.PIXEL_WIDTH(24), .WORD_WIDTH(32), .PACK_MODE(PACK_PADDED), .OVF_WIDTH(16)) uPadded (
    .i_clock(clock), .i_reset(reset), .i_hdmiData(hdmiData), .i_hdmiEnable(hdmiEnable),
    .i_hdmiFrameEnd(hdmiFrameEnd), .i_fifoFull(fifoFull), .i_clearOverflow(clearOverflow),
    .o_dataValid(pValid), .o_fifoData(pData), .o_overflow(pOvf), .o_overflowCount(pOvfCount));

  hdmi_pixel_packer #(.PIXEL_WIDTH(24), .WORD_WIDTH(32), .PACK_MODE(PACK_DENSE), .OVF_WIDTH(2)) uSat (
    .i_clock(clock), .i_reset(reset), .i_hdmiData(hdmiData), .i_hdmiEnable(hdmiEnable),
    .i_hdmiFrameEnd(hdmiFrameEnd), .i_fifoFull(fifoFull), .i_clearOverflow(clearOverflow),
    .o_dataValid(sValid), .o_fifoData(sData), .o_overflow(sOvf), .o_overflowCount(sOvfCount));

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic [23:0] data, input logic fe,
                      input logic full, input logic clr);
    hdmiEnable    = en;
    hdmiData      = data;
    hdmiFrameEnd  = fe;
    fifoFull      = full;
    clearOverflow = clr;
    @(posedge clock);
    #1;
    hdmiEnable    = 1'b0;
    hdmiData      = 24'h0;
    hdmiFrameEnd  = 1'b0;
    fifoFull      = 1'b0;
    clearOverflow = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    checkValue("rst_valid", {31'h0, dValid}, 32'h0);
    checkValue("rst_data", dData, 32'h0);
    checkValue("rst_ovf", {31'h0, dOvf}, 32'h0);
    checkValue("rst_ovfcnt", {16'h0, dOvfCount}, 32'h0);
    reset = 1'b0;

    // Dense 24->32 continuous stream
    step(1'b1, 24'h112233, 1'b0, 1'b0, 1'b0);
    checkValue("dense_p1_novalid", {31'h0, dValid}, 32'h0);
    step(1'b1, 24'h445566, 1'b0, 1'b0, 1'b0);
    checkValue("dense_w1_valid", {31'h0, dValid}, 32'h1);
    checkValue("dense_w1", dData, 32'h66112233);
    step(1'b1, 24'h778899, 1'b0, 1'b0, 1'b0);
    checkValue("dense_w2", dData, 32'h88994455);
    step(1'b1, 24'hAABBCC, 1'b1, 1'b0, 1'b0);
    checkValue("dense_w3_valid", {31'h0, dValid}, 32'h1);
    checkValue("dense_w3", dData, 32'hAABBCC77);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    checkValue("dense_noflush", {31'h0, dValid}, 32'h0);
    checkValue("dense_hold", dData, 32'hAABBCC77);

    // Frame end coinciding with a full word defers the flush one cycle
    step(1'b1, 24'h112233, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h445566, 1'b0, 1'b0, 1'b0);
    checkValue("flush_w1", dData, 32'h66112233);
    step(1'b1, 24'h778899, 1'b1, 1'b0, 1'b0);
    checkValue("flush_w2", dData, 32'h88994455);
    step(1'b1, 24'h010203, 1'b0, 1'b0, 1'b0);
    checkValue("flush_pend_valid", {31'h0, dValid}, 32'h1);
    checkValue("flush_pend", dData, 32'h00000077);
    step(1'b1, 24'h040506, 1'b0, 1'b0, 1'b0);
    checkValue("flush_fresh", dData, 32'h06010203);
    checkValue("flush_fresh_valid", {31'h0, dValid}, 32'h1);

    // Immediate flush of a lone residual pixel
    applyReset();
    step(1'b1, 24'h112233, 1'b1, 1'b0, 1'b0);
    checkValue("iflush_valid", {31'h0, dValid}, 32'h1);
    checkValue("iflush", dData, 32'h00112233);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    checkValue("iflush_once", {31'h0, dValid}, 32'h0);

    // Padded mode
    step(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
    checkValue("pad_valid", {31'h0, pValid}, 32'h1);
    checkValue("pad_word", pData, 32'h00ABCDEF);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    checkValue("pad_noflush", {31'h0, pValid}, 32'h0);
    step(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0);
    checkValue("pad_word2", pData, 32'h00000001);

    // Overflow: drop second word, alignment continues
    applyReset();
    step(1'b1, 24'h112233, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h445566, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h778899, 1'b0, 1'b1, 1'b0);
    checkValue("ovf_drop_valid", {31'h0, dValid}, 32'h0);
    checkValue("ovf_drop_hold", dData, 32'h66112233);
    checkValue("ovf_cnt1", {16'h0, dOvfCount}, 32'h1);
    checkValue("ovf_flag1", {31'h0, dOvf}, 32'h1);
    step(1'b1, 24'hAABBCC, 1'b0, 1'b0, 1'b0);
    checkValue("ovf_w3", dData, 32'hAABBCC77);
    step(1'b1, 24'h112233, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h445566, 1'b0, 1'b1, 1'b1);
    checkValue("ovf_clr_drop_cnt", {16'h0, dOvfCount}, 32'h1);
    checkValue("ovf_clr_drop_flag", {31'h0, dOvf}, 32'h1);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    checkValue("ovf_clr_cnt", {16'h0, dOvfCount}, 32'h0);
    checkValue("ovf_clr_flag", {31'h0, dOvf}, 32'h0);

    // Saturation with a 2-bit counter: five drops
    applyReset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 24'h123456, 1'b1, 1'b1, 1'b0);
      if (i == 2) checkValue("sat_cnt3", {30'h0, sOvfCount}, 32'h3);
    end
    checkValue("sat_hold", {30'h0, sOvfCount}, 32'h3);
    checkValue("sat_wide_cnt", {16'h0, dOvfCount}, 32'h5);
    checkValue("sat_no_valid", {31'h0, sValid}, 32'h0);

    // Async reset mid-word discards residual bits
    step(1'b1, 24'h112233, 1'b1, 1'b0, 1'b0);
    checkValue("arst_pre", dData, 32'h00112233);
    step(1'b1, 24'h112233, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    checkValue("arst_data", dData, 32'h0);
    checkValue("arst_valid", {31'h0, dValid}, 32'h0);
    checkValue("arst_ovfcnt", {16'h0, dOvfCount}, 32'h0);
    checkValue("arst_ovf", {31'h0, dOvf}, 32'h0);
    #1;
    reset = 1'b0;
    step(1'b1, 24'h445566, 1'b0, 1'b0, 1'b0);
    checkValue("arst_p1_novalid", {31'h0, dValid}, 32'h0);
    step(1'b1, 24'h778899, 1'b0, 1'b0, 1'b0);
    checkValue("arst_fresh", dData, 32'h99445566);
    checkValue("arst_fresh_valid", {31'h0, dValid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
